// File: rtl/double_divider.sv
// IEEE-754 double-precision divider z = a / b over stb/ack operand and result streams.
// Unpack, special-case, normalise, restoring mantissa divide (one quotient bit per cycle), round, pack.
module double_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [63:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam int unsigned DW       = 64;
  localparam int unsigned DIV_BITS = 56;
  localparam int unsigned MANT_W   = 53;
  localparam int unsigned FRAC_W   = 52;
  localparam int unsigned EXPF_W   = 11;
  localparam int unsigned EXP_W    = 13;
  localparam int unsigned REM_W    = DIV_BITS - 1;
  localparam int unsigned CNT_W    = 6;

  localparam logic signed [EXP_W-1:0] EXP_BIAS  = 13'sd1023;
  localparam logic signed [EXP_W-1:0] E_SPECIAL = 13'sd1024;
  localparam logic signed [EXP_W-1:0] E_DENORM  = -13'sd1023;
  localparam logic signed [EXP_W-1:0] E_MIN     = -13'sd1022;
  localparam logic signed [EXP_W-1:0] E_MAX     = 13'sd1023;
  localparam logic [DW-1:0]           QNAN      = 64'hFFF8_0000_0000_0000;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SPECIAL_CASES,
    NORMALISE_A,
    NORMALISE_B,
    DIVIDE_0,
    DIVIDE_1,
    DIVIDE_2,
    NORMALISE_1,
    NORMALISE_2,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t                    state, state_d;
  logic [DW-1:0]             a, a_d, b, b_d, z, z_d;
  logic [MANT_W-1:0]         a_m, a_m_d, b_m, b_m_d, z_m, z_m_d;
  logic signed [EXP_W-1:0]   a_e, a_e_d, b_e, b_e_d, z_e, z_e_d;
  logic                      a_s, a_s_d, b_s, b_s_d, z_s, z_s_d;
  logic                      guard, guard_d, round_bit, round_bit_d, sticky, sticky_d;
  logic [DIV_BITS-1:0]       quotient, quotient_d;
  logic [REM_W-1:0]          remainder, remainder_d;
  logic [CNT_W-1:0]          count, count_d;
  logic                      input_a_ack_d, input_b_ack_d, output_z_stb_d;
  logic [DW-1:0]             output_z_d;

  // Operand classification, valid while in SPECIAL_CASES (mantissas still without hidden bit)
  logic a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c, sign_c;
  assign a_nan_c  = (a_e == E_SPECIAL) && (|a_m);
  assign b_nan_c  = (b_e == E_SPECIAL) && (|b_m);
  assign a_inf_c  = (a_e == E_SPECIAL) && !(|a_m);
  assign b_inf_c  = (b_e == E_SPECIAL) && !(|b_m);
  assign a_zero_c = (a_e == E_DENORM) && !(|a_m);
  assign b_zero_c = (b_e == E_DENORM) && !(|b_m);
  assign sign_c   = a_s ^ b_s;

  // Restoring divide step: trial subtract of the divisor from the partial remainder
  logic             rem_ge_c;
  logic [REM_W-1:0] rem_keep_c;
  assign rem_ge_c   = remainder >= REM_W'(b_m);
  assign rem_keep_c = rem_ge_c ? (remainder - REM_W'(b_m)) : remainder;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      a            <= '0;
      b            <= '0;
      z            <= '0;
      a_m          <= '0;
      b_m          <= '0;
      z_m          <= '0;
      a_e          <= '0;
      b_e          <= '0;
      z_e          <= '0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      z_s          <= 1'b0;
      guard        <= 1'b0;
      round_bit    <= 1'b0;
      sticky       <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      count        <= '0;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z     <= '0;
      output_z_stb <= 1'b0;
    end else begin
      state        <= state_d;
      a            <= a_d;
      b            <= b_d;
      z            <= z_d;
      a_m          <= a_m_d;
      b_m          <= b_m_d;
      z_m          <= z_m_d;
      a_e          <= a_e_d;
      b_e          <= b_e_d;
      z_e          <= z_e_d;
      a_s          <= a_s_d;
      b_s          <= b_s_d;
      z_s          <= z_s_d;
      guard        <= guard_d;
      round_bit    <= round_bit_d;
      sticky       <= sticky_d;
      quotient     <= quotient_d;
      remainder    <= remainder_d;
      count        <= count_d;
      input_a_ack  <= input_a_ack_d;
      input_b_ack  <= input_b_ack_d;
      output_z     <= output_z_d;
      output_z_stb <= output_z_stb_d;
    end
  end

  always_comb begin
    state_d        = state;
    a_d            = a;
    b_d            = b;
    z_d            = z;
    a_m_d          = a_m;
    b_m_d          = b_m;
    z_m_d          = z_m;
    a_e_d          = a_e;
    b_e_d          = b_e;
    z_e_d          = z_e;
    a_s_d          = a_s;
    b_s_d          = b_s;
    z_s_d          = z_s;
    guard_d        = guard;
    round_bit_d    = round_bit;
    sticky_d       = sticky;
    quotient_d     = quotient;
    remainder_d    = remainder;
    count_d        = count;
    output_z_d     = output_z;
    output_z_stb_d = output_z_stb;

    case (state)
      GET_A: begin
        if (input_a_ack && input_a_stb) begin
          a_d     = input_a;
          state_d = GET_B;
        end
      end

      GET_B: begin
        if (input_b_ack && input_b_stb) begin
          b_d     = input_b;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        a_m_d   = {1'b0, a[FRAC_W-1:0]};
        b_m_d   = {1'b0, b[FRAC_W-1:0]};
        a_e_d   = $signed(EXP_W'(a[DW-2:FRAC_W])) - EXP_BIAS;
        b_e_d   = $signed(EXP_W'(b[DW-2:FRAC_W])) - EXP_BIAS;
        a_s_d   = a[DW-1];
        b_s_d   = b[DW-1];
        state_d = SPECIAL_CASES;
      end

      SPECIAL_CASES: begin
        state_d = PUT_Z;
        if (a_nan_c || b_nan_c) begin
          z_d = QNAN;
        end else if (a_inf_c && b_inf_c) begin
          z_d = QNAN;
        end else if (a_inf_c) begin
          z_d = {sign_c, {EXPF_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (b_inf_c) begin
          z_d = {sign_c, {(DW-1){1'b0}}};
        end else if (a_zero_c && b_zero_c) begin
          z_d = QNAN;
        end else if (b_zero_c) begin
          z_d = {sign_c, {EXPF_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_zero_c) begin
          z_d = {sign_c, {(DW-1){1'b0}}};
        end else begin
          // Denormals take the minimum exponent; normals regain the hidden bit
          if (a_e == E_DENORM) a_e_d = E_MIN;
          else                 a_m_d[MANT_W-1] = 1'b1;
          if (b_e == E_DENORM) b_e_d = E_MIN;
          else                 b_m_d[MANT_W-1] = 1'b1;
          state_d = NORMALISE_A;
        end
      end

      NORMALISE_A: begin
        if (!a_m[MANT_W-1]) begin
          a_m_d = {a_m[MANT_W-2:0], 1'b0};
          a_e_d = a_e - 13'sd1;
        end else begin
          state_d = NORMALISE_B;
        end
      end

      NORMALISE_B: begin
        if (!b_m[MANT_W-1]) begin
          b_m_d = {b_m[MANT_W-2:0], 1'b0};
          b_e_d = b_e - 13'sd1;
        end else begin
          state_d = DIVIDE_0;
        end
      end

      DIVIDE_0: begin
        z_s_d       = sign_c;
        z_e_d       = a_e - b_e;
        remainder_d = REM_W'(a_m);
        quotient_d  = '0;
        count_d     = '0;
        state_d     = DIVIDE_1;
      end

      DIVIDE_1: begin
        quotient_d  = {quotient[DIV_BITS-2:0], rem_ge_c};
        remainder_d = {rem_keep_c[REM_W-2:0], 1'b0};
        count_d     = count + CNT_W'(1);
        if (count == CNT_W'(DIV_BITS - 1)) state_d = DIVIDE_2;
      end

      DIVIDE_2: begin
        z_m_d       = quotient[DIV_BITS-1:3];
        guard_d     = quotient[2];
        round_bit_d = quotient[1];
        sticky_d    = quotient[0] | (|remainder);
        state_d     = NORMALISE_1;
      end

      NORMALISE_1: begin
        if (!z_m[MANT_W-1]) begin
          z_m_d       = {z_m[MANT_W-2:0], guard};
          guard_d     = round_bit;
          round_bit_d = 1'b0;
          z_e_d       = z_e - 13'sd1;
        end else begin
          state_d = NORMALISE_2;
        end
      end

      // Denormalise results below the minimum normal exponent
      NORMALISE_2: begin
        if (z_e < E_MIN) begin
          z_m_d       = {1'b0, z_m[MANT_W-1:1]};
          z_e_d       = z_e + 13'sd1;
          guard_d     = z_m[0];
          round_bit_d = guard;
          sticky_d    = sticky | round_bit;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (guard && (round_bit || sticky || z_m[0])) begin
          z_m_d = z_m + MANT_W'(1);
          if (z_m == {MANT_W{1'b1}}) z_e_d = z_e + 13'sd1;
        end
        state_d = PACK;
      end

      PACK: begin
        z_d = {z_s, EXPF_W'(z_e + EXP_BIAS), z_m[FRAC_W-1:0]};
        if (z_e == E_MIN && !z_m[MANT_W-1]) z_d[DW-2:FRAC_W] = '0;
        if (z_e > E_MAX) z_d = {z_s, {EXPF_W{1'b1}}, {FRAC_W{1'b0}}};
        state_d = PUT_Z;
      end

      PUT_Z: begin
        output_z_stb_d = 1'b1;
        output_z_d     = z;
        if (output_z_stb && output_z_ack) begin
          output_z_stb_d = 1'b0;
          state_d        = GET_A;
        end
      end

      default: state_d = GET_A;
    endcase

    // Ready is high from the first cycle spent in each operand state
    input_a_ack_d = (state_d == GET_A);
    input_b_ack_d = (state_d == GET_B);
  end

endmodule

// File: tb/tb_double_divider.sv
// Directed bench for double_divider: results, latencies, specials, range edges, backpressure, reset.
module tb_double_divider;

  localparam int unsigned TIMEOUT = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   lat;
  logic held_ok;
  logic quiet_ok;

  double_divider dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the b transfer edge
  task automatic send_ops(input string tag, input logic [63:0] a, input logic [63:0] b);
    int t;
    input_a     = a;
    input_a_stb = 1'b1;
    t = 0;
    while (!input_a_ack && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_a_ack"}, 64'(input_a_ack), 64'd1);
    @(negedge clk);
    input_a_stb = 1'b0;
    input_b     = b;
    input_b_stb = 1'b1;
    t = 0;
    while (!input_b_ack && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_b_ack"}, 64'(input_b_ack), 64'd1);
    @(negedge clk);
    input_b_stb = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!output_z_stb && cycles < TIMEOUT);
    check({tag, "_stb_seen"}, 64'(output_z_stb), 64'd1);
  endtask

  task automatic take_result(input string tag);
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    check({tag, "_stb_drop"}, 64'(output_z_stb), 64'd0);
    check({tag, "_a_ready"}, 64'(input_a_ack), 64'd1);
  endtask

  task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_z, input int exp_lat);
    int cyc;
    send_ops(tag, a, b);
    wait_result(tag, cyc);
    check({tag, "_z"}, output_z, exp_z);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    take_result(tag);
  endtask

  initial begin
    rst          = 1'b0;
    input_a      = '0;
    input_a_stb  = 1'b0;
    input_b      = '0;
    input_b_stb  = 1'b0;
    output_z_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a_ack", 64'(input_a_ack), 64'd0);
    check("reset_b_ack", 64'(input_b_ack), 64'd0);
    check("reset_stb", 64'(output_z_stb), 64'd0);
    check("reset_z", output_z, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("first_a_ack", 64'(input_a_ack), 64'd1);

    // Main function
    run_div("six_by_two", 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 67);
    run_div("one_third", 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 68);
    run_div("one_tenth", 64'h3FF0000000000000, 64'h4024000000000000, 64'h3FB999999999999A, 68);

    // Special operands
    run_div("one_by_zero", 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 3);
    run_div("zero_by_zero", 64'h0000000000000000, 64'h0000000000000000, 64'hFFF8000000000000, 3);
    run_div("neg_by_inf", 64'hBFF0000000000000, 64'h7FF0000000000000, 64'h8000000000000000, 3);
    run_div("inf_by_inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 64'hFFF8000000000000, 3);
    run_div("nan_by_one", 64'h7FF0000000000001, 64'h3FF0000000000000, 64'hFFF8000000000000, 3);

    // Range edges
    run_div("denorm_out", 64'h0010000000000000, 64'h4000000000000000, 64'h0008000000000000, 68);
    run_div("overflow", 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 67);
    run_div("denorm_in", 64'h0000000000000001, 64'h0010000000000000, 64'h3CB0000000000000, 119);

    // Result held under backpressure
    send_ops("hold", 64'h401C000000000000, 64'h4000000000000000);
    wait_result("hold", lat);
    check("hold_lat", 64'(lat), 64'd67);
    held_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!output_z_stb || output_z !== 64'h400C000000000000) held_ok = 1'b0;
    end
    check("hold_stable", 64'(held_ok), 64'd1);
    check("hold_z", output_z, 64'h400C000000000000);
    take_result("hold");

    // Asynchronous reset in the middle of the divide loop
    send_ops("rst_div", 64'h4018000000000000, 64'h4000000000000000);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_div_a_ack", 64'(input_a_ack), 64'd0);
    check("rst_div_b_ack", 64'(input_b_ack), 64'd0);
    check("rst_div_stb", 64'(output_z_stb), 64'd0);
    check("rst_div_z", output_z, 64'd0);
    @(negedge clk);
    check("rst_hold_a_ack", 64'(input_a_ack), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_a_ack", 64'(input_a_ack), 64'd1);
    quiet_ok = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (output_z_stb) quiet_ok = 1'b0;
    end
    check("rst_aborted", 64'(quiet_ok), 64'd1);
    run_div("post_rst", 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 67);

    // Asynchronous reset while a result waits to be taken
    send_ops("rst_put", 64'h3FF0000000000000, 64'h4008000000000000);
    wait_result("rst_put", lat);
    check("rst_put_z_before", output_z, 64'h3FD5555555555555);
    #2 rst = 1'b0;
    #1;
    check("rst_put_stb", 64'(output_z_stb), 64'd0);
    check("rst_put_z", output_z, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_put_a_ack", 64'(input_a_ack), 64'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
